// File: rtl/vga_ctrl_pkg.sv
// Shared constants for the VGA pattern controller: scroll FSM encoding and size defaults.
// Pure declarations, no logic, no latency, no flow control.
package vga_ctrl_pkg;

   localparam int H_LIMIT_DEF = 639;
   localparam int SPEED_W_DEF = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_BAD   = 2'd3
   } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for W independent asynchronous level pins.
// Latency 2 clk cycles; no backpressure, samples every cycle.
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/scroll_sequencer.sv
// Per-frame horizontal scroll sequencer (wrap/bounce, run/pause/single-step) for the pattern datapath.
// Outputs update one clk after frame_tick, i.e. once per frame; no backpressure, pins sampled via sync2.
module scroll_sequencer
   import vga_ctrl_pkg::*;
#(
   parameter int H_LIMIT = H_LIMIT_DEF,
   parameter int SPEED_W = SPEED_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               vsync,
   input  logic               run,
   input  logic               pause,
   input  logic               step,
   input  logic               bounce,
   input  logic               dir,
   input  logic [SPEED_W-1:0] speed,
   output logic [9:0]         scroll_x,
   output logic               frame_tick,
   output logic [7:0]         frame_cnt,
   output logic [1:0]         state,
   output logic               dir_out
);

   localparam int          SW   = SPEED_W + 5;
   localparam logic [10:0] LIM  = 11'(H_LIMIT);
   localparam logic [10:0] LIM1 = 11'(H_LIMIT + 1);

   logic [SW-1:0]      pins_s;
   logic               run_s, pause_s, step_s, bounce_s, dir_s;
   logic [SPEED_W-1:0] speed_s;
   logic               vsync_q, step_q, step_pending, idir;
   state_t             state_q, state_nxt;
   logic [10:0]        sum_up, sum_dn;
   logic [9:0]         x_nxt;
   logic               idir_nxt, dout_nxt, moving;

   sync2 #(.W(SW)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     ({run, pause, step, bounce, dir, speed}),
      .q     (pins_s)
   );

   assign {run_s, pause_s, step_s, bounce_s, dir_s, speed_s} = pins_s;
   assign state = state_q;

   // History flop resets high so a vsync already high at release is not an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vsync_q    <= 1'b1;
         frame_tick <= 1'b0;
         frame_cnt  <= 8'd0;
      end else begin
         vsync_q    <= vsync;
         frame_tick <= vsync & ~vsync_q;
         if (frame_tick)
            frame_cnt <= frame_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      if (state_q == ST_BAD)
         state_nxt = ST_IDLE;
      else if (frame_tick) begin
         if (!run_s)
            state_nxt = ST_IDLE;
         else begin
            case (state_q)
               ST_IDLE:  state_nxt = ST_RUN;
               ST_RUN:   if (pause_s)  state_nxt = ST_PAUSE;
               ST_PAUSE: if (!pause_s) state_nxt = ST_RUN;
               default:  state_nxt = ST_IDLE;
            endcase
         end
      end
   end

   assign moving = frame_tick && (speed_s != '0) &&
                   (state_q == ST_RUN || (state_q == ST_PAUSE && step_pending));

   // Position update, selected by the state held before this tick's transition.
   always_comb begin
      sum_up   = {1'b0, scroll_x} + 11'(speed_s);
      sum_dn   = {1'b0, scroll_x} - 11'(speed_s);
      x_nxt    = scroll_x;
      idir_nxt = idir;
      dout_nxt = dir_out;
      if (frame_tick && state_q == ST_IDLE) begin
         x_nxt    = '0;
         idir_nxt = 1'b0;
         dout_nxt = 1'b0;
      end else if (moving) begin
         if (!bounce_s) begin
            idir_nxt = dir_s;
            dout_nxt = dir_s;
            if (!dir_s)
               x_nxt = (sum_up > LIM) ? 10'(sum_up - LIM1) : 10'(sum_up);
            else if ({1'b0, scroll_x} < 11'(speed_s))
               x_nxt = 10'(sum_dn + LIM1);
            else
               x_nxt = 10'(sum_dn);
         end else begin
            if (!idir) begin
               if (sum_up >= LIM) begin
                  x_nxt    = 10'(H_LIMIT);
                  idir_nxt = 1'b1;
               end else
                  x_nxt = 10'(sum_up);
            end else begin
               if ({1'b0, scroll_x} <= 11'(speed_s)) begin
                  x_nxt    = '0;
                  idir_nxt = 1'b0;
               end else
                  x_nxt = 10'(sum_dn);
            end
            dout_nxt = idir_nxt;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scroll_x <= '0;
         idir     <= 1'b0;
         dir_out  <= 1'b0;
      end else begin
         scroll_x <= x_nxt;
         idir     <= idir_nxt;
         dir_out  <= dout_nxt;
      end
   end

   // A pause tick always consumes the request; several edges in one frame merge into one step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_q       <= 1'b0;
         step_pending <= 1'b0;
      end else begin
         step_q <= step_s;
         if ((frame_tick && state_q == ST_PAUSE) || state_nxt == ST_IDLE)
            step_pending <= 1'b0;
         else if (step_s && !step_q && state_q == ST_PAUSE)
            step_pending <= 1'b1;
      end
   end

endmodule
